// File: rtl/alu_op_sequencer_if.sv
// Command and datapath-strobe bundle between a command source and alu_op_sequencer.
// The sequencer takes the slave side; the control unit / bench takes the master side.
interface alu_op_sequencer_if #(
  parameter int NUM_REGS  = 16,
  parameter int IDX_W     = 4,
  parameter int ALU_SEL_W = 5
);
  logic                 start;
  logic [ALU_SEL_W-1:0] op_sel;
  logic [IDX_W-1:0]     ra;
  logic [IDX_W-1:0]     rb;
  logic [IDX_W-1:0]     rc;
  logic                 imm_mode;
  logic                 wide;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [NUM_REGS-1:0]  Rout;
  logic [NUM_REGS-1:0]  Rin;
  logic                 Yin;
  logic                 Yout;
  logic                 Cout;
  logic                 Zin;
  logic                 ZLOout;
  logic                 ZHIout;
  logic                 LOin;
  logic                 HIin;
  logic [ALU_SEL_W-1:0] alu_sel;

  modport slave (
    input  start, op_sel, ra, rb, rc, imm_mode, wide,
    output busy, done, err, Rout, Rin, Yin, Yout, Cout, Zin,
           ZLOout, ZHIout, LOin, HIin, alu_sel
  );

  modport master (
    output start, op_sel, ra, rb, rc, imm_mode, wide,
    input  busy, done, err, Rout, Rin, Yin, Yout, Cout, Zin,
           ZLOout, ZHIout, LOin, HIin, alu_sel
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Steps the CPU datapath through load-Y / execute / write-back for one
// register-register or register-immediate ALU command at a time.
module alu_op_sequencer #(
  parameter int NUM_REGS  = 16,
  parameter int IDX_W     = 4,
  parameter int ALU_SEL_W = 5
) (
  input  logic                clk,
  input  logic                clr,
  alu_op_sequencer_if.slave   bus,
  output logic [2:0]          dbg_state
);

  // Handshake: start is a command valid strobe. It is taken on the rising edge
  // where busy is low (IDLE); busy is the inverse of ready, so a start seen
  // while busy is dropped, never queued. done pulses for one cycle when the
  // command completes, with err alongside it if the command was rejected.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_Y = 3'd1,
    S_EXEC   = 3'd2,
    S_WB_LO  = 3'd3,
    S_WB_HI  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [IDX_W:0]    NREGS_W = (IDX_W+1)'(NUM_REGS);
  localparam logic [NUM_REGS-1:0] ONE   = NUM_REGS'(1);

  state_t               state, state_nx;
  logic [ALU_SEL_W-1:0] op_q;
  logic [IDX_W-1:0]     ra_q, rb_q, rc_q;
  logic                 imm_q, wide_q, err_q;
  logic                 accept, bad_cmd;

  assign accept  = (state == S_IDLE) && bus.start;
  assign bad_cmd = ({1'b0, bus.rb} >= NREGS_W)
                || (!bus.imm_mode && ({1'b0, bus.rc} >= NREGS_W))
                || (!bus.wide     && ({1'b0, bus.ra} >= NREGS_W));
  assign dbg_state = state;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= S_IDLE;
      op_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      rc_q   <= '0;
      imm_q  <= 1'b0;
      wide_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q   <= bus.op_sel;
        ra_q   <= bus.ra;
        rb_q   <= bus.rb;
        rc_q   <= bus.rc;
        imm_q  <= bus.imm_mode;
        wide_q <= bus.wide;
        err_q  <= bad_cmd;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (bus.start) state_nx = bad_cmd ? S_DONE : S_LOAD_Y;
      S_LOAD_Y: state_nx = S_EXEC;
      S_EXEC:   state_nx = S_WB_LO;
      S_WB_LO:  state_nx = wide_q ? S_WB_HI : S_DONE;
      S_WB_HI:  state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Outputs depend only on the registered state and latched fields.
  always_comb begin
    bus.busy    = (state != S_IDLE);
    bus.done    = 1'b0;
    bus.err     = 1'b0;
    bus.Rout    = '0;
    bus.Rin     = '0;
    bus.Yin     = 1'b0;
    bus.Yout    = 1'b0;
    bus.Cout    = 1'b0;
    bus.Zin     = 1'b0;
    bus.ZLOout  = 1'b0;
    bus.ZHIout  = 1'b0;
    bus.LOin    = 1'b0;
    bus.HIin    = 1'b0;
    bus.alu_sel = '0;
    case (state)
      S_LOAD_Y: begin
        bus.Rout = ONE << rb_q;
        bus.Yin  = 1'b1;
      end
      S_EXEC: begin
        bus.Yout    = 1'b1;
        bus.Zin     = 1'b1;
        bus.alu_sel = op_q;
        if (imm_q) bus.Cout = 1'b1;
        else       bus.Rout = ONE << rc_q;
      end
      S_WB_LO: begin
        bus.ZLOout  = 1'b1;
        bus.alu_sel = op_q;
        if (wide_q) bus.LOin = 1'b1;
        else        bus.Rin  = ONE << ra_q;
      end
      S_WB_HI: begin
        bus.ZHIout  = 1'b1;
        bus.HIin    = 1'b1;
        bus.alu_sel = op_q;
      end
      S_DONE: begin
        bus.done = 1'b1;
        bus.err  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios then random commands, each
// cycle's strobes compared against a per-command expected-cycle list.
module tb_alu_op_sequencer;
  localparam int NR = 12;
  localparam int IW = 4;
  localparam int SW = 5;
  localparam int W  = 3 + 2*NR + 8 + SW;

  // strobe byte order: {Yin, Yout, Cout, Zin, ZLOout, ZHIout, LOin, HIin}
  localparam logic [7:0] ST_YIN  = 8'h80;
  localparam logic [7:0] ST_YOUT = 8'h40;
  localparam logic [7:0] ST_COUT = 8'h20;
  localparam logic [7:0] ST_ZIN  = 8'h10;
  localparam logic [7:0] ST_ZLO  = 8'h08;
  localparam logic [7:0] ST_ZHI  = 8'h04;
  localparam logic [7:0] ST_LO   = 8'h02;
  localparam logic [7:0] ST_HI   = 8'h01;

  logic       clk;
  logic       clr;
  logic [2:0] dbg_state;
  int         checks;
  int         failures;
  int         cyc;
  int         last_done;
  int         t0;
  logic [W-1:0] exp_q[$];

  alu_op_sequencer_if #(.NUM_REGS(NR), .IDX_W(IW), .ALU_SEL_W(SW)) bus ();

  alu_op_sequencer #(.NUM_REGS(NR), .IDX_W(IW), .ALU_SEL_W(SW)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(logic b, logic d, logic e,
                                        logic [NR-1:0] ro, logic [NR-1:0] ri,
                                        logic [7:0] st, logic [SW-1:0] al);
    return {b, d, e, ro, ri, st, al};
  endfunction

  function automatic logic [NR-1:0] oh(int idx);
    logic [NR-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Reference model: the cycle-by-cycle output picture of one command.
  function automatic void push_cmd(int op, int ra, int rb, int rc, bit imm, bit wide);
    logic [SW-1:0] o;
    bit bad;
    o = SW'(op);
    bad = (rb >= NR) || (!imm && rc >= NR) || (!wide && ra >= NR);
    if (bad) begin
      exp_q.push_back(pack(1, 1, 1, '0, '0, 8'h00, '0));
      return;
    end
    exp_q.push_back(pack(1, 0, 0, oh(rb), '0, ST_YIN, '0));
    exp_q.push_back(pack(1, 0, 0, imm ? '0 : oh(rc), '0,
                         ST_YOUT | ST_ZIN | (imm ? ST_COUT : 8'h00), o));
    if (wide) begin
      exp_q.push_back(pack(1, 0, 0, '0, '0, ST_ZLO | ST_LO, o));
      exp_q.push_back(pack(1, 0, 0, '0, '0, ST_ZHI | ST_HI, o));
    end else begin
      exp_q.push_back(pack(1, 0, 0, '0, oh(ra), ST_ZLO, o));
    end
    exp_q.push_back(pack(1, 1, 0, '0, '0, 8'h00, '0));
  endfunction

  // scoreboard compare
  task automatic check(string tag, logic [W-1:0] e);
    logic [W-1:0] o;
    o = pack(bus.busy, bus.done, bus.err, bus.Rout, bus.Rin,
             {bus.Yin, bus.Yout, bus.Cout, bus.Zin, bus.ZLOout, bus.ZHIout, bus.LOin, bus.HIin},
             bus.alu_sel);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_inv(string tag);
    checks++;
    assert ($countones(bus.Rout) <= 1 && $countones(bus.Rin) <= 1 && !(bus.Yin && bus.Zin)) else begin
      failures++;
      $error("FAIL %s_inv observed Rout=%h Rin=%h Yin=%b Zin=%b expected onehot0/exclusive",
             tag, bus.Rout, bus.Rin, bus.Yin, bus.Zin);
    end
  endtask

  task automatic drive_rand();
    bus.op_sel   = SW'($urandom_range(0, 31));
    bus.ra       = IW'($urandom_range(0, 15));
    bus.rb       = IW'($urandom_range(0, 15));
    bus.rc       = IW'($urandom_range(0, 15));
    bus.imm_mode = 1'($urandom_range(0, 1));
    bus.wide     = 1'($urandom_range(0, 1));
  endtask

  // Issue one command from IDLE and follow it to completion.
  task automatic run_cmd(string tag, int op, int ra, int rb, int rc, bit imm, bit wide, bit spam);
    int n;
    @(negedge clk); cyc++;
    check({tag, "_idle"}, pack(0, 0, 0, '0, '0, 8'h00, '0));
    bus.start    = 1'b1;
    bus.op_sel   = SW'(op);
    bus.ra       = IW'(ra);
    bus.rb       = IW'(rb);
    bus.rc       = IW'(rc);
    bus.imm_mode = imm;
    bus.wide     = wide;
    push_cmd(op, ra, rb, rc, imm, wide);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk); cyc++;
      if (spam) drive_rand();
      else      bus.start = 1'b0;
      check($sformatf("%s_c%0d", tag, i), exp_q.pop_front());
      check_inv(tag);
      if (bus.done) last_done = cyc;
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; last_done = 0; t0 = 0;
    clr = 1'b0;
    bus.start = 1'b0; bus.op_sel = '0; bus.ra = '0; bus.rb = '0; bus.rc = '0;
    bus.imm_mode = 1'b0; bus.wide = 1'b0;

    // reset
    #1;
    check("reset_async", pack(0, 0, 0, '0, '0, 8'h00, '0));
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    check("reset_held", pack(0, 0, 0, '0, '0, 8'h00, '0));
    bus.start = 1'b0;
    clr = 1'b1;

    // directed: narrow, immediate, wide, rejected then valid
    run_cmd("narrow", 5'b00010, 0, 4, 5, 1'b0, 1'b0, 1'b0);
    run_cmd("imm",    5'b00011, 3, 1, 15, 1'b1, 1'b0, 1'b0);
    run_cmd("wide",   5'b01110, 15, 4, 5, 1'b0, 1'b1, 1'b0);
    run_cmd("bad_rb", 5'b00010, 0, 13, 5, 1'b0, 1'b0, 1'b0);
    run_cmd("bad_rc", 5'b00010, 0, 2, 12, 1'b0, 1'b0, 1'b0);
    run_cmd("bad_ra", 5'b00010, 12, 2, 3, 1'b0, 1'b0, 1'b0);
    run_cmd("after_bad", 5'b00101, 11, 11, 11, 1'b0, 1'b0, 1'b0);

    // start held in every cycle, then back-to-back acceptance
    run_cmd("spam", 5'b00001, 2, 6, 7, 1'b0, 1'b0, 1'b1);
    t0 = last_done;
    run_cmd("b2b", 5'b00100, 1, 3, 3, 1'b0, 1'b0, 1'b0);
    checks++;
    assert (last_done - t0 === 5) else begin
      failures++;
      $error("FAIL b2b_spacing observed=%0d expected=5", last_done - t0);
    end

    // reset in the middle of EXEC
    @(negedge clk); cyc++;
    bus.start = 1'b1; bus.op_sel = 5'b00110; bus.ra = 4'd1; bus.rb = 4'd2; bus.rc = 4'd3;
    bus.imm_mode = 1'b0; bus.wide = 1'b1;
    @(negedge clk); cyc++;
    bus.start = 1'b0;
    @(negedge clk); cyc++;
    check("pre_abort_exec", pack(1, 0, 0, oh(3), '0, ST_YOUT | ST_ZIN, 5'b00110));
    clr = 1'b0;
    #1;
    check("abort_now", pack(0, 0, 0, '0, '0, 8'h00, '0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); cyc++;
      check($sformatf("abort_hold%0d", i), pack(0, 0, 0, '0, '0, 8'h00, '0));
    end
    clr = 1'b1;
    run_cmd("post_abort", 5'b00111, 9, 8, 10, 1'b0, 1'b0, 1'b0);

    // random commands (indices 12..15 are out of range for NR=12)
    for (int k = 0; k < 40; k++) begin
      run_cmd($sformatf("rnd%0d", k), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("final_idle", pack(0, 0, 0, '0, '0, 8'h00, '0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Control sequencer that replaces hand-driven T3..T5 control stepping for register-register and register-immediate ALU operations on the CPU datapath. It accepts one command (op, destination, sources, mode), then drives one-hot register out/in enables, Y/Z/HI/LO strobes and the ALU select for the correct number of cycles. It sits between the future control unit (or a bench) and the existing CPU datapath, and generalises register count, select width and result width.

Parameters:
NUM_REGS, 16, number of general registers; width of the one-hot Rout/Rin buses
IDX_W, 4, register index width; must satisfy 2**IDX_W >= NUM_REGS
ALU_SEL_W, 5, width of the ALU operation select

Ports:
clk  in  1  rising-edge clock
clr  in  1  asynchronous active-low reset
start  in  1  command valid; sampled only in IDLE
op_sel  in  ALU_SEL_W  ALU operation code, passed through to alu_sel
ra  in  IDX_W  destination register index (ignored when wide=1)
rb  in  IDX_W  first source index (loaded into Y)
rc  in  IDX_W  second source index (ignored when imm_mode=1)
imm_mode  in  1  1 = second operand from Cout (sign-extended constant path) instead of rc
wide  in  1  1 = 64-bit result written to LO then HI (mul/div); 0 = low 32 bits written to ra
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at command completion
err  out  1  one-cycle pulse with done when the command is rejected
Rout  out  NUM_REGS  one-hot register-to-bus enables
Rin  out  NUM_REGS  one-hot bus-to-register enables
Yin  out  1  Y register load
Yout  out  1  Y onto ALU A input
Cout  out  1  constant onto bus
Zin  out  1  Z (64-bit) load
ZLOout  out  1  Z low half onto bus
ZHIout  out  1  Z high half onto bus
LOin  out  1  LO load
HIin  out  1  HI load
alu_sel  out  ALU_SEL_W  ALU select

Behaviour:
- clr low: state=IDLE immediately; all outputs 0, including alu_sel; latched command cleared. Reset mid-command aborts it with no done pulse.
- Command fields latched on the edge where start=1 in IDLE. Inputs are don't-care afterwards. start while busy is ignored and not queued.
- Validation at acceptance: rb>=NUM_REGS, rc>=NUM_REGS with imm_mode=0, or ra>=NUM_REGS with wide=0 -> go to DONE with err=1. No datapath strobe is asserted.
- States: IDLE, LOAD_Y, EXEC, WB_LO, WB_HI, DONE. Outputs are decoded from the registered state and the latched fields only, with no combinational path from inputs.
- LOAD_Y: Rout[rb]=1, Yin=1.
- EXEC: Yout=1, Zin=1, alu_sel=op. Rout[rc]=1 when imm_mode=0; Cout=1 when imm_mode=1.
- WB_LO: ZLOout=1, alu_sel=op. wide=0: Rin[ra]=1, next state DONE. wide=1: LOin=1, next state WB_HI.
- WB_HI: ZHIout=1, HIin=1, alu_sel=op, next state DONE.
- DONE: done=1; err=1 for a rejected command; next state IDLE. busy=1 in DONE.
- alu_sel is 0 in IDLE, LOAD_Y and DONE.
- At most one Rout bit and one Rin bit are high at any time. Yin never coincides with Zin.
- Latency, counted from the accepting edge to the done-high cycle: narrow 3 cycles busy before DONE (4 busy cycles total); wide 5 busy cycles total; rejected command 1 busy cycle.
- Next command can be accepted on the edge after DONE, i.e. earliest start is the first IDLE cycle.
- ra=0 is a legal destination; R0 write semantics belong to the datapath.
- rb=rc is legal.

Test Plan:
- Reset: R4=10, R5=2. Command op=5'b00010, rb=4, rc=5, ra=0, narrow -> Rout[4]&Yin, then Yout&Rout[5]&Zin&alu_sel=00010, then ZLOout&Rin[0], then done. Datapath R0=8. busy high for 4 cycles.
- Immediate: rb=1 (R1=18), imm_mode=1, op=add with constant 0x12 -> EXEC shows Cout=1 and Rout=0. R3=0x24 when ra=3.
- Wide: rb=4, rc=5, op=mul, wide=1 -> WB_LO asserts LOin and WB_HI asserts HIin. LO=20, HI=0. Rin=0 throughout. busy high for 5 cycles.
- Illegal index: NUM_REGS=12, rb=13 -> busy for 1 cycle, done=err=1 together, no strobes asserted. Next valid command completes normally.
- start pulsed in every cycle of a command -> only the first is taken. A second start in the first IDLE after done is accepted, giving back-to-back done pulses 5 cycles apart.
- clr dropped in the middle of EXEC -> all outputs 0 within the same cycle, no done pulse. After release, a fresh command runs correctly.
